// File: rtl/softmax_max_frame_server_if.sv
// Load stream, data2/data1 frame handshake and counter feedback between the max frame server
// and the softmax subtract consumer.
interface softmax_max_frame_server_if #(
    parameter int unsigned count_width = 8
);
    logic                   in_valid;
    logic [15:0]            in_data;
    logic                   in_last;
    logic                   in_ready;
    logic                   data2_en;
    logic [15:0]            data2_o;
    logic                   data1_req;
    logic                   data1_en;
    logic [15:0]            data1_o;
    logic                   outc;
    logic [count_width-1:0] count_o;
    logic [count_width-1:0] last_count_o;
    logic                   vec_done;
    logic                   trunc_o;

    modport master (
        input  in_valid, in_data, in_last, data1_req, outc,
        output in_ready, data2_en, data2_o, data1_en, data1_o, count_o, last_count_o,
               vec_done, trunc_o
    );

    modport slave (
        output in_valid, in_data, in_last, data1_req, outc,
        input  in_ready, data2_en, data2_o, data1_en, data1_o, count_o, last_count_o,
               vec_done, trunc_o
    );
endinterface

// File: rtl/softmax_max_frame_server.sv
// Buffers one Q7.8 vector while tracking its signed maximum, announces the maximum on data2,
// then serves stored elements on data1 under the consumer's outc-driven element counter.
module softmax_max_frame_server #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned count_width = 8
) (
    input logic                         clk,
    input logic                         rst,
    softmax_max_frame_server_if.master  bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StLoad, StAnnounce, StServe, StDone} state_e;

    state_e                 state_q;
    logic [count_width-1:0] wr_ptr_q;
    logic [count_width-1:0] count_q;
    logic [count_width-1:0] last_count_q;
    logic [15:0]            max_q;
    logic [15:0]            data2_q;
    logic                   data2_en_q;
    logic                   vec_done_q;
    logic                   trunc_q;
    logic [15:0]            mem [DEPTH];

    logic        accept;
    logic        first_beat;
    logic        at_end;
    logic        last_elem;
    logic [15:0] max_next;

    assign accept     = bus.in_valid && (state_q == StLoad);
    assign first_beat = (wr_ptr_q == '0);
    assign at_end     = (wr_ptr_q == count_width'(DEPTH - 1));
    assign last_elem  = (count_q == last_count_q - count_width'(1));

    // Strict greater-than keeps the held maximum on ties.
    always_comb begin
        max_next = max_q;
        if (first_beat || ($signed(bus.in_data) > $signed(max_q))) begin
            max_next = bus.in_data;
        end
    end

    // Storage is not reset; contents are only meaningful below last_count_q.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            mem[wr_ptr_q[AW-1:0]] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StLoad;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            last_count_q <= '0;
            max_q        <= '0;
            data2_q      <= '0;
            data2_en_q   <= 1'b0;
            vec_done_q   <= 1'b0;
            trunc_q      <= 1'b0;
        end else begin
            data2_en_q <= 1'b0;
            vec_done_q <= 1'b0;
            unique case (state_q)
                StLoad: begin
                    if (accept) begin
                        wr_ptr_q <= wr_ptr_q + count_width'(1);
                        max_q    <= max_next;
                        if (first_beat) begin
                            trunc_q <= 1'b0;
                        end
                        if (bus.in_last) begin
                            last_count_q <= wr_ptr_q + count_width'(1);
                            data2_q      <= max_next;
                            data2_en_q   <= 1'b1;
                            state_q      <= StAnnounce;
                        end else if (at_end) begin
                            // Buffer full without in_last: close the vector here and flag it.
                            last_count_q <= count_width'(DEPTH);
                            trunc_q      <= 1'b1;
                            data2_q      <= max_next;
                            data2_en_q   <= 1'b1;
                            state_q      <= StAnnounce;
                        end
                    end
                end
                StAnnounce: begin
                    count_q <= '0;
                    state_q <= StServe;
                end
                StServe: begin
                    if (bus.outc) begin
                        if (last_elem) begin
                            count_q    <= '0;
                            vec_done_q <= 1'b1;
                            state_q    <= StDone;
                        end else begin
                            count_q <= count_q + count_width'(1);
                        end
                    end
                end
                StDone: begin
                    wr_ptr_q <= '0;
                    state_q  <= StLoad;
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    assign bus.in_ready     = (state_q == StLoad);
    assign bus.data2_en     = data2_en_q;
    assign bus.data2_o      = data2_q;
    assign bus.data1_en     = bus.data1_req && (state_q == StServe) && (count_q < last_count_q);
    assign bus.data1_o      = mem[count_q[AW-1:0]];
    assign bus.count_o      = count_q;
    assign bus.last_count_o = last_count_q;
    assign bus.vec_done     = vec_done_q;
    assign bus.trunc_o      = trunc_q;
endmodule

// File: tb/tb_softmax_max_frame_server.sv
// Randomized and directed bench for softmax_max_frame_server against a queue-based vector model.
module tb_softmax_max_frame_server;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    softmax_max_frame_server_if #(.count_width(CW)) bus ();

    softmax_max_frame_server #(
        .DEPTH       (DEPTH),
        .count_width (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    logic [15:0] vec_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] exp_max;
    bit          exp_trunc;

    // Accepted beats are the first min(n, DEPTH); max is a plain signed scan over them.
    function automatic void model(input bit use_last);
        exp_q.delete();
        for (int i = 0; i < vec_q.size() && i < int'(DEPTH); i++) exp_q.push_back(vec_q[i]);
        exp_max = exp_q[0];
        foreach (exp_q[i]) if ($signed(exp_q[i]) > $signed(exp_max)) exp_max = exp_q[i];
        exp_trunc = !(use_last && vec_q.size() <= int'(DEPTH));
    endfunction

    task automatic load_vec(input bit use_last, input bit hold_extra);
        model(use_last);
        foreach (exp_q[i]) begin
            @(negedge clk);
            check("in_ready_load", bus.in_ready, 1);
            bus.in_valid = 1'b1;
            bus.in_data  = exp_q[i];
            bus.in_last  = use_last && (i == vec_q.size() - 1);
        end
        @(negedge clk);
        bus.in_valid = hold_extra;
        bus.in_data  = 16'h1234;
        bus.in_last  = 1'b0;
        check("data2_en_pulse", bus.data2_en, 1);
        check("data2_o", bus.data2_o, exp_max);
        check("last_count", bus.last_count_o, exp_q.size());
        check("trunc", bus.trunc_o, exp_trunc);
        check("in_ready_announce", bus.in_ready, 0);
        @(negedge clk);
        check("data2_en_single", bus.data2_en, 0);
    endtask

    task automatic serve_vec(input int gap, input bit rnd);
        foreach (exp_q[idx]) begin
            int w;
            w = rnd ? $urandom_range(0, gap) : gap;
            repeat (w) begin
                logic req;
                @(negedge clk);
                req = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.data1_req = req;
                bus.outc      = 1'b0;
                #1;
                check("data1_en_wait", bus.data1_en, req);
                check("count_wait", bus.count_o, idx);
                check("data1_o_wait", bus.data1_o, exp_q[idx]);
                check("in_ready_serve", bus.in_ready, 0);
            end
            @(negedge clk);
            bus.data1_req = 1'b1;
            bus.outc      = 1'b1;
            #1;
            check("data1_en_outc", bus.data1_en, 1);
            check("data1_o", bus.data1_o, exp_q[idx]);
            check("count_outc", bus.count_o, idx);
            check("vec_done_early", bus.vec_done, 0);
        end
        @(negedge clk);
        bus.outc      = 1'b0;
        bus.data1_req = 1'b0;
        bus.in_valid  = 1'b0;
        check("vec_done_pulse", bus.vec_done, 1);
        check("count_done", bus.count_o, 0);
        check("in_ready_done", bus.in_ready, 0);
        @(negedge clk);
        check("vec_done_single", bus.vec_done, 0);
        check("in_ready_after", bus.in_ready, 1);
    endtask

    task automatic stray_outc();
        @(negedge clk);
        bus.outc = 1'b1;
        @(negedge clk);
        bus.outc = 1'b0;
        check("stray_count", bus.count_o, 0);
        check("stray_vec_done", bus.vec_done, 0);
        check("stray_data2_en", bus.data2_en, 0);
        check("stray_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.data1_req = 1'b0;
        bus.outc      = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_count", bus.count_o, 0);
        check("rst_last_count", bus.last_count_o, 0);
        check("rst_data2_o", bus.data2_o, 0);
        check("rst_data2_en", bus.data2_en, 0);
        check("rst_vec_done", bus.vec_done, 0);
        check("rst_trunc", bus.trunc_o, 0);

        stray_outc();

        vec_q = '{16'h0100, 16'hFF00, 16'h0280, 16'h0040};
        load_vec(1'b1, 1'b0);
        check("dir_max_0280", bus.data2_o, 16'h0280);
        serve_vec(3, 1'b0);
        stray_outc();

        vec_q = '{16'h8000, 16'hFFFF};
        load_vec(1'b1, 1'b0);
        serve_vec(1, 1'b1);

        vec_q = '{16'h8000};
        load_vec(1'b1, 1'b0);
        serve_vec(2, 1'b1);

        // 17 beats, no in_last: beat 17 stays pending until the vector is served.
        vec_q.delete();
        for (int i = 0; i < 17; i++) vec_q.push_back(16'($urandom));
        load_vec(1'b0, 1'b1);
        serve_vec(2, 1'b1);

        // Reset mid-serve at count 2.
        vec_q = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        load_vec(1'b1, 1'b0);
        @(negedge clk);
        bus.data1_req = 1'b1;
        bus.outc      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.outc = 1'b0;
        check("pre_rst_count", bus.count_o, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.data1_req = 1'b0;
        check("midrst_count", bus.count_o, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_data2_en", bus.data2_en, 0);
        check("midrst_vec_done", bus.vec_done, 0);
        @(negedge clk);
        check("midrst_vec_done2", bus.vec_done, 0);
        vec_q = '{16'hFFF0, 16'h0005};
        load_vec(1'b1, 1'b0);
        serve_vec(2, 1'b1);

        for (int v = 0; v < 25; v++) begin
            int  len;
            bit  use_last;
            len      = $urandom_range(1, 20);
            use_last = (len < int'(DEPTH)) ? 1'b1 :
                       (len == int'(DEPTH)) ? 1'($urandom_range(0, 1)) : 1'b0;
            vec_q.delete();
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 7))
                    0:       vec_q.push_back(16'h8000);
                    1:       vec_q.push_back(16'h7FFF);
                    default: vec_q.push_back(16'($urandom));
                endcase
            end
            load_vec(use_last, 1'b0);
            serve_vec(4, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
